// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: accepts an exception, interrupt or mret from
// the core, performs the CSR updates one per cycle, then issues a one-cycle
// PC redirect to the handler (mtvec) or back to the saved mepc.
module trap_controller #(
    parameter logic [31:0] INT_CAUSE = 32'h8000000B,
    parameter logic [1:0]  MPP_M     = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        illegal_inst,
    input  logic        ecall,
    input  logic        load_fault,
    input  logic        store_fault,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic [31:0] pc_cur,
    input  logic [31:0] inst,
    input  logic [31:0] fault_addr,
    input  logic [31:0] mstatus,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        csr_w,
    output logic [1:0]  csr_wsc_mode,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [1:0]  MODE_WRITE  = 2'b01;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_LOAD    = 32'd5;
    localparam logic [31:0] CAUSE_STORE   = 32'd7;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_MEPC   = 3'd1,
        W_MCAUSE = 3'd2,
        W_MTVAL  = 3'd3,
        W_MSTAT  = 3'd4,
        RET_STAT = 3'd5,
        REDIR    = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] epc_r;
    logic [31:0] cause_r;
    logic [31:0] tval_r;
    logic [31:0] tgt_r;

    logic        irq_take_s;
    logic        trap_req_s;
    logic [31:0] take_cause_s;
    logic [31:0] take_tval_s;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- machine.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = MPP_M;
        return r;
    endfunction

    // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- machine.
    function automatic logic [31:0] ret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = MPP_M;
        return r;
    endfunction

    // Event priority decode: cause and trap value of the winning request.
    always_comb begin
        irq_take_s   = ext_irq & mstatus[3];
        trap_req_s   = irq_take_s | illegal_inst | ecall | load_fault | store_fault;
        take_cause_s = 32'd0;
        take_tval_s  = 32'd0;
        if (irq_take_s) begin
            take_cause_s = INT_CAUSE;
        end else if (illegal_inst) begin
            take_cause_s = CAUSE_ILLEGAL;
            take_tval_s  = inst;
        end else if (ecall) begin
            take_cause_s = CAUSE_ECALL;
        end else if (load_fault) begin
            take_cause_s = CAUSE_LOAD;
            take_tval_s  = fault_addr;
        end else if (store_fault) begin
            take_cause_s = CAUSE_STORE;
            take_tval_s  = fault_addr;
        end else begin
            take_cause_s = 32'd0;
            take_tval_s  = 32'd0;
        end
    end

    // Next-state logic; events are only looked at while IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (trap_req_s) begin
                    next_state_s = W_MEPC;
                end else if (mret) begin
                    next_state_s = RET_STAT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            W_MEPC:   next_state_s = W_MCAUSE;
            W_MCAUSE: next_state_s = W_MTVAL;
            W_MTVAL:  next_state_s = W_MSTAT;
            W_MSTAT:  next_state_s = REDIR;
            RET_STAT: next_state_s = REDIR;
            REDIR:    next_state_s = IDLE;
            default:  next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Trap context capture at accept time and redirect target capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_r   <= 32'd0;
            cause_r <= 32'd0;
            tval_r  <= 32'd0;
            tgt_r   <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (trap_req_s) begin
                        epc_r   <= pc_cur;
                        cause_r <= take_cause_s;
                        tval_r  <= take_tval_s;
                    end
                end
                W_MSTAT:  tgt_r <= {csr_rdata[31:2], 2'b00};
                RET_STAT: tgt_r <= csr_rdata;
                default: begin
                end
            endcase
        end
    end

    // Per-state CSR port, stall and redirect drive; quiet defaults first.
    always_comb begin
        csr_raddr    = CSR_MSTATUS;
        csr_waddr    = 12'h000;
        csr_wdata    = 32'd0;
        csr_w        = 1'b0;
        csr_wsc_mode = MODE_WRITE;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        case (state_r)
            IDLE: begin
                // Stall the accepting cycle itself; never while reset is held.
                if (!rst && (trap_req_s || mret)) begin
                    stall = 1'b1;
                end else begin
                    stall = 1'b0;
                end
            end
            W_MEPC: begin
                stall     = 1'b1;
                csr_w     = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = epc_r;
            end
            W_MCAUSE: begin
                stall     = 1'b1;
                csr_w     = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_r;
            end
            W_MTVAL: begin
                stall     = 1'b1;
                csr_w     = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = tval_r;
            end
            W_MSTAT: begin
                stall     = 1'b1;
                csr_w     = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = trap_mstatus(mstatus);
                csr_raddr = CSR_MTVEC;
            end
            RET_STAT: begin
                stall     = 1'b1;
                csr_w     = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = ret_mstatus(mstatus);
                csr_raddr = CSR_MEPC;
            end
            REDIR: begin
                stall       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = tgt_r;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized
// events compared against a cycle-indexed model of the trap/return sequence.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        illegal_inst, ecall, load_fault, store_fault, mret, ext_irq;
    logic [31:0] pc_cur, inst, fault_addr, mstatus;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic        stall, redirect;
    logic [31:0] redirect_pc;

    logic [31:0] mtvec_v, mepc_v;
    int          checks = 0;
    int          errors = 0;
    int          noise_mode = 0;   // 0: quiet, 1: random events, 2: all events

    logic        exp_w[0:7],     obs_w[0:7];
    logic [11:0] exp_waddr[0:7], obs_waddr[0:7];
    logic [31:0] exp_wdata[0:7], obs_wdata[0:7];
    logic        exp_stall[0:7], obs_stall[0:7];
    logic        exp_redir[0:7], obs_redir[0:7];
    logic [31:0] exp_rpc[0:7],   obs_rpc[0:7];
    logic [11:0] exp_raddr[0:7], obs_raddr[0:7];

    trap_controller dut (
        .clk(clk), .rst(rst),
        .illegal_inst(illegal_inst), .ecall(ecall), .load_fault(load_fault),
        .store_fault(store_fault), .mret(mret), .ext_irq(ext_irq),
        .pc_cur(pc_cur), .inst(inst), .fault_addr(fault_addr), .mstatus(mstatus),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_w(csr_w),
        .csr_wsc_mode(csr_wsc_mode), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Minimal CSR file read port seen by the DUT.
    assign csr_rdata = (csr_raddr == 12'h305) ? mtvec_v :
                       (csr_raddr == 12'h341) ? mepc_v  : mstatus;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_events(input bit irq, il, ec, ld, st, mr);
        ext_irq      = irq;
        illegal_inst = il;
        ecall        = ec;
        load_fault   = ld;
        store_fault  = st;
        mret         = mr;
    endtask

    // Expected per-cycle outputs, cycle 0 = accept cycle, built from the rules.
    task automatic model_event(input bit irq, il, ec, ld, st, mr,
                               input logic [31:0] ms, pc, ins, fa, tvec, epc,
                               output int len);
        logic [31:0] cause, tval, nms;
        bit trap;
        for (int k = 0; k < 8; k++) begin
            exp_w[k] = 1'b0; exp_waddr[k] = 12'h000; exp_wdata[k] = 32'd0;
            exp_stall[k] = 1'b0; exp_redir[k] = 1'b0; exp_rpc[k] = 32'd0;
            exp_raddr[k] = 12'h300;
        end
        trap = (irq && ms[3]) || il || ec || ld || st;
        cause = 32'd0; tval = 32'd0;
        if (irq && ms[3]) cause = 32'h8000000B;
        else if (il) begin cause = 32'd2;  tval = ins; end
        else if (ec) cause = 32'd11;
        else if (ld) begin cause = 32'd5;  tval = fa; end
        else if (st) begin cause = 32'd7;  tval = fa; end
        if (trap) begin
            nms = ms; nms[7] = ms[3]; nms[3] = 1'b0; nms[12:11] = 2'b11;
            for (int k = 0; k <= 5; k++) exp_stall[k] = 1'b1;
            for (int k = 1; k <= 4; k++) exp_w[k] = 1'b1;
            exp_waddr[1] = 12'h341; exp_wdata[1] = pc;
            exp_waddr[2] = 12'h342; exp_wdata[2] = cause;
            exp_waddr[3] = 12'h343; exp_wdata[3] = tval;
            exp_waddr[4] = 12'h300; exp_wdata[4] = nms;
            exp_raddr[4] = 12'h305;
            exp_redir[5] = 1'b1;    exp_rpc[5] = tvec & 32'hFFFF_FFFC;
            len = 6;
        end else if (mr) begin
            nms = ms; nms[3] = ms[7]; nms[7] = 1'b1; nms[12:11] = 2'b11;
            for (int k = 0; k <= 2; k++) exp_stall[k] = 1'b1;
            exp_w[1] = 1'b1; exp_waddr[1] = 12'h300; exp_wdata[1] = nms;
            exp_raddr[1] = 12'h341;
            exp_redir[2] = 1'b1; exp_rpc[2] = epc;
            len = 3;
        end else begin
            len = 0;
        end
    endtask

    // Sample cycles 0..n_last at negedge; inputs from cycle idle_at on are quiet.
    task automatic capture(input int n_last, input int idle_at);
        for (int k = 0; k <= n_last; k++) begin
            @(negedge clk);
            obs_w[k] = csr_w; obs_waddr[k] = csr_waddr; obs_wdata[k] = csr_wdata;
            obs_stall[k] = stall; obs_redir[k] = redirect; obs_rpc[k] = redirect_pc;
            obs_raddr[k] = csr_raddr;
            if (k == n_last) break;
            @(posedge clk); #1;
            if (k + 1 >= idle_at || noise_mode == 0)
                drive_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else if (noise_mode == 2)
                drive_events(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            else
                drive_events($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mstatus = 32'h8; pc_cur = 32'h40; inst = 32'h13; fault_addr = 32'h0;
        mtvec_v = 32'h0; mepc_v = 32'h0;
        drive_events(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        checks++;
        if (stall !== 1'b0 || csr_w !== 1'b0 || redirect !== 1'b0 || redirect_pc !== 32'd0 ||
            csr_waddr !== 12'h000 || csr_wdata !== 32'd0 || csr_wsc_mode !== 2'b01 ||
            csr_raddr !== 12'h300) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b w=%b redir=%b rpc=%h waddr=%h wdata=%h mode=%b raddr=%h, want 0 0 0 0 000 0 01 300",
                     stall, csr_w, redirect, redirect_pc, csr_waddr, csr_wdata, csr_wsc_mode, csr_raddr);
        end
        drive_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || csr_w !== 1'b0 || redirect !== 1'b0 || csr_raddr !== 12'h300) begin
            errors++;
            $display("FAIL idle_after_reset: got stall=%b w=%b redir=%b raddr=%h, want 0 0 0 300",
                     stall, csr_w, redirect, csr_raddr);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] ea[1:4];
        logic [31:0] ed[1:4];
        ea[1] = 12'h341; ed[1] = 32'h100;
        ea[2] = 12'h342; ed[2] = 32'd2;
        ea[3] = 12'h343; ed[3] = 32'hFFFF_FFFF;
        ea[4] = 12'h300; ed[4] = 32'h1880;
        noise_mode = 0;
        @(posedge clk); #1;
        pc_cur = 32'h100; inst = 32'hFFFF_FFFF; mstatus = 32'h88; mtvec_v = 32'h200;
        drive_events(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        capture(6, 6);
        checks++;
        if (obs_stall[0] !== 1'b1 || obs_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_accept: got stall=%b w=%b, want 1 0", obs_stall[0], obs_w[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (obs_w[k] !== 1'b1 || obs_waddr[k] !== ea[k] || obs_wdata[k] !== ed[k]) begin
                errors++;
                $display("FAIL illegal_write%0d: got w=%b %h<=%h, want 1 %h<=%h",
                         k, obs_w[k], obs_waddr[k], obs_wdata[k], ea[k], ed[k]);
            end
        end
        checks++;
        if (obs_redir[5] !== 1'b1 || obs_rpc[5] !== 32'h200 || obs_redir[4] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_redirect: got redir[4]=%b redir[5]=%b pc=%h, want 0 1 200",
                     obs_redir[4], obs_redir[5], obs_rpc[5]);
        end
        checks++;
        if (obs_stall[6] !== 1'b0 || obs_w[6] !== 1'b0 || obs_redir[6] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_return_idle: got stall=%b w=%b redir=%b, want 0 0 0",
                     obs_stall[6], obs_w[6], obs_redir[6]);
        end
    endtask

    task automatic test_irq_priority();
        noise_mode = 0;
        @(posedge clk); #1;
        pc_cur = 32'h500; mstatus = 32'h8; mtvec_v = 32'h300;
        drive_events(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        capture(6, 6);
        checks++;
        if (obs_wdata[2] !== 32'h8000000B || obs_wdata[3] !== 32'd0) begin
            errors++;
            $display("FAIL irq_wins: got mcause=%h mtval=%h, want 8000000b 0", obs_wdata[2], obs_wdata[3]);
        end
        @(posedge clk); #1;
        mstatus = 32'h0;
        drive_events(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        capture(6, 6);
        checks++;
        if (obs_wdata[2] !== 32'd11 || obs_waddr[2] !== 12'h342) begin
            errors++;
            $display("FAIL irq_masked_ecall: got %h<=%h, want 342<=0000000b", obs_waddr[2], obs_wdata[2]);
        end
        @(posedge clk); #1;
        drive_events(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        capture(1, 1);
        checks++;
        if (obs_stall[0] !== 1'b0 || obs_w[1] !== 1'b0 || obs_stall[1] !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked_idle: got stall0=%b w1=%b stall1=%b, want 0 0 0",
                     obs_stall[0], obs_w[1], obs_stall[1]);
        end
    endtask

    task automatic test_mret();
        noise_mode = 0;
        @(posedge clk); #1;
        mstatus = 32'h1880; mepc_v = 32'h104;
        drive_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        capture(3, 3);
        checks++;
        if (obs_stall[0] !== 1'b1 || obs_stall[1] !== 1'b1 || obs_stall[2] !== 1'b1 || obs_stall[3] !== 1'b0) begin
            errors++;
            $display("FAIL mret_stall: got %b%b%b%b, want 1110",
                     obs_stall[0], obs_stall[1], obs_stall[2], obs_stall[3]);
        end
        checks++;
        if (obs_w[1] !== 1'b1 || obs_waddr[1] !== 12'h300 || obs_wdata[1] !== 32'h1888 || obs_raddr[1] !== 12'h341) begin
            errors++;
            $display("FAIL mret_write: got w=%b %h<=%h raddr=%h, want 1 300<=1888 341",
                     obs_w[1], obs_waddr[1], obs_wdata[1], obs_raddr[1]);
        end
        checks++;
        if (obs_redir[1] !== 1'b0 || obs_redir[2] !== 1'b1 || obs_rpc[2] !== 32'h104) begin
            errors++;
            $display("FAIL mret_redirect: got redir1=%b redir2=%b pc=%h, want 0 1 104",
                     obs_redir[1], obs_redir[2], obs_rpc[2]);
        end
    endtask

    task automatic test_busy_mask();
        int len;
        noise_mode = 2;
        @(posedge clk); #1;
        mstatus = 32'h8; fault_addr = 32'h8000; pc_cur = 32'h220; mtvec_v = 32'h400;
        drive_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        model_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mstatus, pc_cur, inst, fault_addr,
                    mtvec_v, mepc_v, len);
        capture(len, len);
        checks++;
        if (obs_wdata[2] !== 32'd7 || obs_wdata[3] !== 32'h8000) begin
            errors++;
            $display("FAIL busy_cause_tval: got mcause=%h mtval=%h, want 7 8000", obs_wdata[2], obs_wdata[3]);
        end
        for (int k = 0; k <= len; k++) begin
            checks++;
            if (obs_w[k] !== exp_w[k] || obs_waddr[k] !== exp_waddr[k] || obs_wdata[k] !== exp_wdata[k] ||
                obs_redir[k] !== exp_redir[k] || obs_stall[k] !== exp_stall[k]) begin
                errors++;
                $display("FAIL busy_cycle%0d: got w=%b %h<=%h redir=%b stall=%b, want w=%b %h<=%h redir=%b stall=%b",
                         k, obs_w[k], obs_waddr[k], obs_wdata[k], obs_redir[k], obs_stall[k],
                         exp_w[k], exp_waddr[k], exp_wdata[k], exp_redir[k], exp_stall[k]);
            end
        end
        noise_mode = 0;
    endtask

    task automatic test_reset_abort();
        noise_mode = 0;
        @(posedge clk); #1;
        mstatus = 32'h8; pc_cur = 32'h600; inst = 32'h0; mtvec_v = 32'h700;
        drive_events(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        capture(3, 3);
        checks++;
        if (obs_w[3] !== 1'b1 || obs_waddr[3] !== 12'h343) begin
            errors++;
            $display("FAIL abort_reached_mtval: got w=%b addr=%h, want 1 343", obs_w[3], obs_waddr[3]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || csr_w !== 1'b0 || redirect !== 1'b0 || csr_waddr !== 12'h000 || csr_wdata !== 32'd0) begin
            errors++;
            $display("FAIL abort_immediate: got stall=%b w=%b redir=%b waddr=%h wdata=%h, want 0 0 0 000 0",
                     stall, csr_w, redirect, csr_waddr, csr_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (csr_w !== 1'b0 || redirect !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet%0d: got w=%b redir=%b stall=%b, want 0 0 0", k, csr_w, redirect, stall);
            end
        end
    endtask

    task automatic test_back_to_back();
        int len;
        noise_mode = 0;
        @(posedge clk); #1;
        mstatus = 32'h8; pc_cur = 32'h900; mtvec_v = 32'hA01;
        drive_events(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        capture(5, 6);
        checks++;
        if (obs_redir[5] !== 1'b1 || obs_rpc[5] !== 32'hA00) begin
            errors++;
            $display("FAIL b2b_trap_redirect: got redir=%b pc=%h, want 1 a00", obs_redir[5], obs_rpc[5]);
        end
        @(posedge clk); #1;
        mstatus = 32'h1800; mepc_v = 32'h904;
        drive_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mstatus, pc_cur, inst, fault_addr,
                    mtvec_v, mepc_v, len);
        capture(len, len);
        for (int k = 0; k <= len; k++) begin
            checks++;
            if (obs_w[k] !== exp_w[k] || obs_wdata[k] !== exp_wdata[k] || obs_redir[k] !== exp_redir[k] ||
                obs_rpc[k] !== exp_rpc[k] || obs_stall[k] !== exp_stall[k]) begin
                errors++;
                $display("FAIL b2b_mret_cycle%0d: got w=%b data=%h redir=%b pc=%h stall=%b, want %b %h %b %h %b",
                         k, obs_w[k], obs_wdata[k], obs_redir[k], obs_rpc[k], obs_stall[k],
                         exp_w[k], exp_wdata[k], exp_redir[k], exp_rpc[k], exp_stall[k]);
            end
        end
    endtask

    task automatic test_random();
        int len;
        bit irq, il, ec, ld, st, mr;
        for (int it = 0; it < 60; it++) begin
            noise_mode = $urandom_range(0, 1);
            irq = ($urandom_range(0, 2) == 0); il = ($urandom_range(0, 3) == 0);
            ec  = ($urandom_range(0, 3) == 0); ld = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 3) == 0); mr = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            mstatus = $urandom; pc_cur = $urandom; inst = $urandom; fault_addr = $urandom;
            mtvec_v = $urandom; mepc_v = $urandom;
            drive_events(irq, il, ec, ld, st, mr);
            model_event(irq, il, ec, ld, st, mr, mstatus, pc_cur, inst, fault_addr,
                        mtvec_v, mepc_v, len);
            capture(len, len);
            for (int k = 0; k <= len; k++) begin
                checks++;
                if (obs_w[k] !== exp_w[k] || obs_waddr[k] !== exp_waddr[k] || obs_wdata[k] !== exp_wdata[k] ||
                    obs_stall[k] !== exp_stall[k] || obs_redir[k] !== exp_redir[k] ||
                    obs_rpc[k] !== exp_rpc[k] || obs_raddr[k] !== exp_raddr[k]) begin
                    errors++;
                    $display("FAIL rand%0d_cycle%0d: got w=%b %h<=%h stall=%b redir=%b pc=%h raddr=%h, want w=%b %h<=%h stall=%b redir=%b pc=%h raddr=%h",
                             it, k, obs_w[k], obs_waddr[k], obs_wdata[k], obs_stall[k], obs_redir[k], obs_rpc[k], obs_raddr[k],
                             exp_w[k], exp_waddr[k], exp_wdata[k], exp_stall[k], exp_redir[k], exp_rpc[k], exp_raddr[k]);
                end
            end
            drive_events(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        noise_mode = 0;
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_irq_priority();
        test_mret();
        test_busy_mask();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
